pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Program-counter and fetch stage that drives the instruction ROM address and registers the returned word.
//  Presents it to decode through a valid/ready handshake, and accepts branch/jump redirects back from decode.
//  Sits directly upstream of the instruction memory; the ROM's combinational data returns the same cycle.
//  Detects jump-to-self as end of program and halts.
// PARAMETERS
//  WIDTH     32  instruction/address width (bits)
//  DEPTH     8   log2 of ROM word count; ROM spans byte addresses 0 .. 4*2**DEPTH-1
//  RESET_PC  0   PC value loaded on reset
// PORTS
//  clk           in   1       clock, rising edge
//  rst           in   1       asynchronous reset, active-high
//  instr_addr    out  WIDTH   byte address to ROM; equals pc register (combinational)
//  instr_data    in   WIDTH   ROM word for instr_addr, same cycle
//  instr_out     out  WIDTH   registered instruction to decode
//  ir_pc         out  WIDTH   byte address of instr_out
//  instr_valid   out  1       instr_out/ir_pc valid
//  instr_ready   in   1       decode accepts instr_out this cycle
//  branch_taken  in   1       redirect: branch for the instruction at ir_pc
//  branch_off    in   16      signed word offset for branch
//  jump          in   1       redirect: J-type for the instruction at ir_pc
//  jump_index    in   26      J-type target index
//  halt_req      in   1       external halt request
//  halted        out  1       block in HALT
//  fault         out  1       out-of-range fetch (macro only, else 0)
//  fetch_count   out  16      accepted-instruction count, saturating at 16'hFFFF
// BEHAVIOUR
//  Reset (async, any cycle, including mid-stall or mid-redirect):
//    pc=RESET_PC, instr_out=0, ir_pc=0, instr_valid=0, halted=0, fault=0, fetch_count=0, state=FETCH.
//  States: FETCH, HALT, FAULT. HALT and FAULT exit only via rst.
//  accept = instr_valid & instr_ready; load = ~instr_valid | instr_ready.
//  Redirects are sampled only on accept; otherwise branch_taken/jump are ignored.
//  Redirect targets:
//    jump:   {ir_pc+4 [WIDTH-1:28], jump_index, 2'b00}
//    branch: ir_pc + 4 + (sext(branch_off) << 2), mod 2**WIDTH
//    jump and branch_taken together -> jump wins.
//  FETCH, priority high to low:
//    halt_req                 -> HALT next cycle; instr_valid<=0; pc frozen.
//    accept & jump to ir_pc   -> HALT; instr_valid<=0; pc frozen.
//    accept & redirect        -> pc<=target; instr_valid<=0 (squash, one bubble).
//    load                     -> instr_out<=instr_data, ir_pc<=pc, instr_valid<=1, pc<=pc+4 (wraps mod 2**WIDTH).
//    valid & ~ready (stall)   -> pc, instr_out, ir_pc held.
//  fetch_count increments on every accept, including the accept that triggers a redirect or HALT.
//  Latency: instruction at pc is visible on instr_out 1 cycle after instr_addr=pc.
//  Throughput: 1 instruction/cycle with ready high; 1 bubble per taken redirect.
//  halted=1 in HALT, combinational from state.
//  HALT: instr_valid=0; outputs frozen; all inputs ignored.
// CONFIGURATION
//  FETCH_BOUNDS_CHECK_EN defined:
//    On load with pc >= 4*2**DEPTH -> FAULT; fault=1, instr_valid=0, pc frozen at the offending value.
//    Redirect targets are checked when fetched, not when loaded.
//  FETCH_BOUNDS_CHECK_EN undefined:
//    No check; fault tied 0; out-of-range pc is fetched and the ROM aliases it.
// TESTING
//  1 Reset: rst pulsed during a stall -> pc=0, instr_addr=0, instr_valid=0, fetch_count=0 without waiting for a clk edge.
//  2 Sequential, ready=1, ROM[0..3] loaded:
//    -> instr_out 0x00008020, 0x20100007, 0x00008820, 0x20110001 at ir_pc 0, 4, 8, 0xC
//    -> one per cycle from cycle 1; fetch_count=4 after the four accepts.
//  3 Branch: accept at ir_pc=0x10, branch_taken=1, branch_off=3 -> pc=0x20, one bubble, next valid ir_pc=0x20.
//  4 Self-jump: accept at ir_pc=0x1C, jump=1, jump_index=7 -> halted=1 next cycle, instr_valid=0, instr_addr stays constant.
//  5 Stall: instr_ready=0 for 3 cycles with instr_valid=1 -> instr_out, ir_pc, pc, fetch_count unchanged; resumes on ready=1.
//  6 Bounds, DEPTH=8, sequential run to pc=0x400:
//    -> with FETCH_BOUNDS_CHECK_EN: fault=1, instr_valid=0
//    -> without FETCH_BOUNDS_CHECK_EN: ir_pc=0x400 delivered, fault=0.

Source files
------------

// File: rtl/pc_fetch_if.sv
// Fetch <-> ROM/decode bundle: ROM address/data, instruction handshake, redirects and status.
// master = fetch unit, slave = ROM + decode side.
interface pc_fetch_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] instr_addr;
  logic [WIDTH-1:0] instr_data;
  logic [WIDTH-1:0] instr_out;
  logic [WIDTH-1:0] ir_pc;
  logic             instr_valid;
  logic             instr_ready;
  logic             branch_taken;
  logic [15:0]      branch_off;
  logic             jump;
  logic [25:0]      jump_index;
  logic             halt_req;
  logic             halted;
  logic             fault;
  logic [15:0]      fetch_count;

  modport master (
    output instr_addr, instr_out, ir_pc, instr_valid, halted, fault, fetch_count,
    input  instr_data, instr_ready, branch_taken, branch_off, jump, jump_index, halt_req
  );

  modport slave (
    input  instr_addr, instr_out, ir_pc, instr_valid, halted, fault, fetch_count,
    output instr_data, instr_ready, branch_taken, branch_off, jump, jump_index, halt_req
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC + fetch stage: drives ROM address, registers the returned word toward decode, takes redirects, halts on jump-to-self.
// Optional macro FETCH_BOUNDS_CHECK_EN: out-of-range fetch enters FAULT instead of aliasing the ROM.
module pc_fetch_unit #(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 8,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  pc_fetch_if.master   bus
);

  typedef enum logic [1:0] {FETCH, HALT, FAULT} state_t;

  localparam logic [WIDTH-1:0] ROM_BYTES = WIDTH'(4) << DEPTH;
`ifdef FETCH_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] ir_pc_q, ir_pc_d;
  logic             valid_q, valid_d;
  logic [15:0]      cnt_q, cnt_d;

  logic             accept, load, redirect, self_jump, oob;
  logic [WIDTH-1:0] seq_pc, jump_tgt, branch_tgt, target;

  assign accept     = valid_q & bus.instr_ready;
  assign load       = ~valid_q | bus.instr_ready;
  assign seq_pc     = ir_pc_q + WIDTH'(3'd4);
  assign jump_tgt   = {seq_pc[WIDTH-1:28], bus.jump_index, 2'b00};
  assign branch_tgt = seq_pc + ({{(WIDTH-16){bus.branch_off[15]}}, bus.branch_off} << 2);
  // jump beats branch when decode asserts both
  assign target     = bus.jump ? jump_tgt : branch_tgt;
  assign redirect   = accept & (bus.jump | bus.branch_taken);
  assign self_jump  = accept & bus.jump & (jump_tgt == ir_pc_q);
  assign oob        = BOUNDS_EN && (pc_q >= ROM_BYTES);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ir_pc_d = ir_pc_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    case (state_q)
      FETCH: begin
        if (accept && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        if (bus.halt_req || self_jump) begin
          state_d = HALT;
          valid_d = 1'b0;
        end else if (redirect) begin
          pc_d    = target;
          valid_d = 1'b0;
        end else if (load) begin
          // redirect targets are range-checked here, when they are actually fetched
          if (oob) begin
            state_d = FAULT;
            valid_d = 1'b0;
          end else begin
            instr_d = bus.instr_data;
            ir_pc_d = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + WIDTH'(3'd4);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      ir_pc_q <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ir_pc_q <= ir_pc_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.instr_addr  = pc_q;
  assign bus.instr_out   = instr_q;
  assign bus.ir_pc       = ir_pc_q;
  assign bus.instr_valid = valid_q;
  assign bus.fetch_count = cnt_q;
  assign bus.halted      = (state_q == HALT);
`ifdef FETCH_BOUNDS_CHECK_EN
  assign bus.fault       = (state_q == FAULT);
`else
  assign bus.fault       = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: ROM model, scoreboard of expected (ir_pc, instr) pairs popped on each accept.
module tb_pc_fetch_unit;
  logic clk;
  logic rst;
  logic [31:0] rom [256];

  pc_fetch_if #(.WIDTH(32)) bus ();

  pc_fetch_unit #(.WIDTH(32), .DEPTH(8), .RESET_PC(32'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.instr_data = rom[bus.instr_addr[9:2]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic clear_inputs();
    bus.instr_ready  = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_off   = 16'h0;
    bus.jump         = 1'b0;
    bus.jump_index   = 26'h0;
    bus.halt_req     = 1'b0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({bus.instr_addr, bus.instr_out, bus.ir_pc, bus.instr_valid, bus.halted, bus.fault, bus.fetch_count}
        !== {32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 16'h0}) begin
      failures++;
      $display("FAIL reset_state got addr=%h out=%h irpc=%h v=%b h=%b f=%b cnt=%h exp all zero",
               bus.instr_addr, bus.instr_out, bus.ir_pc, bus.instr_valid, bus.halted, bus.fault, bus.fetch_count);
    end
    apply_reset();
  endtask

  task automatic test_sequential();
    int cyc = 0, first = -1, acc = 0;
    exp_t e;
    for (int k = 0; k < 4; k++) sb.push_back({32'(k * 4), rom[k]});
    bus.instr_ready = 1'b1;
    while (acc < 4 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (bus.instr_valid) begin
        if (first < 0) first = cyc;
        e = sb.pop_front();
        checks++;
        if ({bus.ir_pc, bus.instr_out} !== {e.pc, e.data}) begin
          failures++;
          $display("FAIL seq_word got pc=%h instr=%h exp pc=%h instr=%h", bus.ir_pc, bus.instr_out, e.pc, e.data);
        end
        acc++;
      end
    end
    checks++;
    if (acc != 4 || first != 1 || cyc != 4) begin
      failures++;
      $display("FAIL seq_timing got accepts=%0d first=%0d last=%0d exp 4 1 4", acc, first, cyc);
    end
    sb.delete();
    @(negedge clk);
    bus.instr_ready = 1'b0;
    checks++;
    if (bus.fetch_count !== 16'd4) begin
      failures++;
      $display("FAIL seq_count got %0d exp 4", bus.fetch_count);
    end
  endtask

  task automatic test_stall();
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({bus.instr_valid, bus.ir_pc, bus.instr_out, bus.instr_addr, bus.fetch_count}
          !== {1'b1, 32'h10, rom[4], 32'h14, 16'd4}) begin
        failures++;
        $display("FAIL stall_hold got v=%b irpc=%h out=%h addr=%h cnt=%0d exp 1 10 %h 14 4",
                 bus.instr_valid, bus.ir_pc, bus.instr_out, bus.instr_addr, bus.fetch_count, rom[4]);
      end
    end
  endtask

  task automatic test_branch();
    exp_t e;
    bus.instr_ready  = 1'b1;
    bus.branch_taken = 1'b1;
    bus.branch_off   = 16'd3;
    @(negedge clk);
    bus.branch_taken = 1'b0;
    checks++;
    if ({bus.instr_valid, bus.instr_addr, bus.fetch_count} !== {1'b0, 32'h20, 16'd5}) begin
      failures++;
      $display("FAIL branch_bubble got v=%b addr=%h cnt=%0d exp 0 20 5", bus.instr_valid, bus.instr_addr, bus.fetch_count);
    end
    sb.push_back({32'h20, rom[8]});
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    if ({bus.instr_valid, bus.ir_pc, bus.instr_out} !== {1'b1, e.pc, e.data}) begin
      failures++;
      $display("FAIL branch_target got v=%b pc=%h instr=%h exp pc=%h instr=%h", bus.instr_valid, bus.ir_pc, bus.instr_out, e.pc, e.data);
    end
    // jump and branch together: jump target 0x40 must win over branch target 0x38
    bus.jump         = 1'b1;
    bus.jump_index   = 26'h10;
    bus.branch_taken = 1'b1;
    bus.branch_off   = 16'd5;
    @(negedge clk);
    bus.jump         = 1'b0;
    bus.branch_taken = 1'b0;
    checks++;
    if ({bus.instr_valid, bus.instr_addr, bus.fetch_count} !== {1'b0, 32'h40, 16'd6}) begin
      failures++;
      $display("FAIL jump_priority got v=%b addr=%h cnt=%0d exp 0 40 6", bus.instr_valid, bus.instr_addr, bus.fetch_count);
    end
    sb.push_back({32'h40, rom[16]});
    @(negedge clk);
    bus.instr_ready = 1'b0;
    e = sb.pop_front();
    checks++;
    if ({bus.instr_valid, bus.ir_pc, bus.instr_out} !== {1'b1, e.pc, e.data}) begin
      failures++;
      $display("FAIL jump_target got v=%b pc=%h instr=%h exp pc=%h instr=%h", bus.instr_valid, bus.ir_pc, bus.instr_out, e.pc, e.data);
    end
  endtask

  task automatic test_reset_stall();
    @(negedge clk);
    checks++;
    if ({bus.instr_valid, bus.instr_addr, bus.fetch_count} !== {1'b1, 32'h44, 16'd6}) begin
      failures++;
      $display("FAIL prereset_stall got v=%b addr=%h cnt=%0d exp 1 44 6", bus.instr_valid, bus.instr_addr, bus.fetch_count);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({bus.instr_addr, bus.instr_valid, bus.fetch_count, bus.ir_pc, bus.instr_out}
        !== {32'h0, 1'b0, 16'h0, 32'h0, 32'h0}) begin
      failures++;
      $display("FAIL async_reset got addr=%h v=%b cnt=%0d irpc=%h out=%h exp all zero",
               bus.instr_addr, bus.instr_valid, bus.fetch_count, bus.ir_pc, bus.instr_out);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_self_jump();
    int cyc = 0, acc = 0;
    exp_t e;
    apply_reset();
    for (int k = 0; k < 8; k++) sb.push_back({32'(k * 4), rom[k]});
    bus.instr_ready = 1'b1;
    while (acc < 8 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (bus.instr_valid) begin
        e = sb.pop_front();
        checks++;
        if ({bus.ir_pc, bus.instr_out} !== {e.pc, e.data}) begin
          failures++;
          $display("FAIL sj_word got pc=%h instr=%h exp pc=%h instr=%h", bus.ir_pc, bus.instr_out, e.pc, e.data);
        end
        if (e.pc == 32'h1C) begin
          bus.jump       = 1'b1;
          bus.jump_index = 26'd7;
        end
        acc++;
      end
    end
    if (acc != 8) begin
      checks++;
      failures++;
      $display("FAIL sj_timeout got accepts=%0d exp 8", acc);
    end
    @(negedge clk);
    bus.jump = 1'b0;
    checks++;
    if ({bus.halted, bus.instr_valid, bus.instr_addr, bus.fetch_count} !== {1'b1, 1'b0, 32'h20, 16'd8}) begin
      failures++;
      $display("FAIL self_jump_halt got h=%b v=%b addr=%h cnt=%0d exp 1 0 20 8", bus.halted, bus.instr_valid, bus.instr_addr, bus.fetch_count);
    end
    bus.branch_taken = 1'b1;
    bus.jump         = 1'b1;
    bus.jump_index   = 26'h3;
    repeat (3) begin
      @(negedge clk);
      bus.halt_req = ~bus.halt_req;
      checks++;
      if ({bus.halted, bus.instr_valid, bus.instr_addr, bus.fetch_count} !== {1'b1, 1'b0, 32'h20, 16'd8}) begin
        failures++;
        $display("FAIL halt_frozen got h=%b v=%b addr=%h cnt=%0d exp 1 0 20 8", bus.halted, bus.instr_valid, bus.instr_addr, bus.fetch_count);
      end
    end
  endtask

  task automatic test_halt_req();
    apply_reset();
    @(negedge clk);
    bus.halt_req = 1'b1;
    @(negedge clk);
    bus.halt_req = 1'b0;
    checks++;
    if ({bus.halted, bus.instr_valid, bus.instr_addr, bus.fetch_count} !== {1'b1, 1'b0, 32'h4, 16'd0}) begin
      failures++;
      $display("FAIL halt_req got h=%b v=%b addr=%h cnt=%0d exp 1 0 4 0", bus.halted, bus.instr_valid, bus.instr_addr, bus.fetch_count);
    end
  endtask

  task automatic test_bounds();
    int cyc = 0, acc = 0;
    exp_t e;
    apply_reset();
    for (int k = 0; k < 256; k++) sb.push_back({32'(k * 4), rom[k]});
    bus.instr_ready = 1'b1;
    while (acc < 256 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (bus.instr_valid) begin
        e = sb.pop_front();
        checks++;
        if ({bus.ir_pc, bus.instr_out} !== {e.pc, e.data}) begin
          failures++;
          $display("FAIL bounds_word got pc=%h instr=%h exp pc=%h instr=%h", bus.ir_pc, bus.instr_out, e.pc, e.data);
        end
        acc++;
      end
    end
    if (acc != 256) begin
      checks++;
      failures++;
      $display("FAIL bounds_timeout got accepts=%0d exp 256", acc);
    end
    @(negedge clk);
    checks++;
`ifdef FETCH_BOUNDS_CHECK_EN
    if ({bus.fault, bus.instr_valid, bus.instr_addr, bus.fetch_count} !== {1'b1, 1'b0, 32'h400, 16'd256}) begin
      failures++;
      $display("FAIL bounds_fault got f=%b v=%b addr=%h cnt=%0d exp 1 0 400 256", bus.fault, bus.instr_valid, bus.instr_addr, bus.fetch_count);
    end
`else
    if ({bus.fault, bus.instr_valid, bus.ir_pc, bus.instr_out, bus.fetch_count} !== {1'b0, 1'b1, 32'h400, rom[0], 16'd256}) begin
      failures++;
      $display("FAIL bounds_alias got f=%b v=%b irpc=%h out=%h cnt=%0d exp 0 1 400 %h 256",
               bus.fault, bus.instr_valid, bus.ir_pc, bus.instr_out, bus.fetch_count, rom[0]);
    end
`endif
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    for (int i = 0; i < 256; i++) rom[i] = 32'hA000_0000 | 32'(i);
    rom[0] = 32'h0000_8020;
    rom[1] = 32'h2010_0007;
    rom[2] = 32'h0000_8820;
    rom[3] = 32'h2011_0001;
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_reset_stall();
    test_self_jump();
    test_halt_req();
    test_bounds();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
